// File: rtl/router_fsm_ctrl.sv
// router_fsm_ctrl: control FSM for the three-output packet router.
// Decodes the header address, sequences header/payload/parity writes into
// the selected FIFO, stalls on FIFO-full and triggers the parity check.
// Ports:
//   clock, resetn (sync, active-low)
//   pkt_valid, parity_done, soft_reset_0..2, fifo_full, low_pkt_valid,
//   fifo_empty_0..2, data_in[1:0]       : status inputs
//   busy, detect_add, ld_state, laf_state, full_state, write_enb_reg,
//   rst_int_reg, lfd_state             : Moore strobes decoded from state
module router_fsm_ctrl (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic       parity_done,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       fifo_full,
    input  logic       low_pkt_valid,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic [1:0] data_in,
    output logic       busy,
    output logic       detect_add,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       lfd_state
);
    typedef enum logic [2:0] {DA, LFD, LD, LP, FFS, LAF, WTE, CPE} state_t;

    state_t     r_state;
    logic [1:0] r_addr;
    logic       w_soft;
    logic       w_empty_live;
    logic       w_empty_lat;

    assign w_soft = soft_reset_0 | soft_reset_1 | soft_reset_2;
    // address 3 maps to "not empty"; DA separately refuses it
    assign w_empty_live = (data_in == 2'd0) ? fifo_empty_0 :
                          (data_in == 2'd1) ? fifo_empty_1 :
                          (data_in == 2'd2) ? fifo_empty_2 : 1'b0;
    assign w_empty_lat  = (r_addr == 2'd0) ? fifo_empty_0 :
                          (r_addr == 2'd1) ? fifo_empty_1 :
                          (r_addr == 2'd2) ? fifo_empty_2 : 1'b0;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= DA;
            r_addr  <= 2'd0;
        end else begin
            if (r_state == DA && pkt_valid)
                r_addr <= data_in;
            if (w_soft)
                r_state <= DA;
            else
                case (r_state)
                    DA:      r_state <= (pkt_valid && data_in != 2'd3) ? (w_empty_live ? LFD : WTE) : DA;
                    LFD:     r_state <= LD;
                    LD:      r_state <= fifo_full ? FFS : (!pkt_valid ? LP : LD);
                    FFS:     r_state <= fifo_full ? FFS : LAF;
                    LAF:     r_state <= parity_done ? DA : (low_pkt_valid ? LP : LD);
                    LP:      r_state <= CPE;
                    CPE:     r_state <= fifo_full ? FFS : DA;
                    WTE:     r_state <= w_empty_lat ? LFD : WTE;
                    default: r_state <= DA;
                endcase
        end
    end

    assign detect_add    = (r_state == DA);
    assign lfd_state     = (r_state == LFD);
    assign ld_state      = (r_state == LD);
    assign laf_state     = (r_state == LAF);
    assign full_state    = (r_state == FFS);
    assign rst_int_reg   = (r_state == CPE);
    assign write_enb_reg = (r_state == LD) | (r_state == LP) | (r_state == LAF);
    assign busy          = !((r_state == DA) | (r_state == LD));
endmodule

// File: tb/tb_router_fsm_ctrl.sv
// tb_router_fsm_ctrl: table-driven check of router_fsm_ctrl state sequencing.
module tb_router_fsm_ctrl;
    logic       clock = 1'b0;
    logic       resetn, pkt_valid, parity_done, fifo_full, low_pkt_valid;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic [1:0] data_in;
    logic       busy, detect_add, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, lfd_state;

    int total = 0;
    int bad   = 0;

    // {busy, detect_add, ld, laf, full, write_enb, rst_int, lfd}
    localparam logic [7:0] S_DA  = 8'b0100_0000;
    localparam logic [7:0] S_LFD = 8'b1000_0001;
    localparam logic [7:0] S_LD  = 8'b0010_0100;
    localparam logic [7:0] S_LP  = 8'b1000_0100;
    localparam logic [7:0] S_FFS = 8'b1000_1000;
    localparam logic [7:0] S_LAF = 8'b1001_0100;
    localparam logic [7:0] S_WTE = 8'b1000_0000;
    localparam logic [7:0] S_CPE = 8'b1000_0010;

    typedef struct packed {
        logic       rn;
        logic       pv;
        logic       pd;
        logic [2:0] sr;
        logic       ff;
        logic       lpv;
        logic [2:0] emp;
        logic [1:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    router_fsm_ctrl dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .parity_done(parity_done),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
        .fifo_full(fifo_full), .low_pkt_valid(low_pkt_valid),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .data_in(data_in), .busy(busy), .detect_add(detect_add), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .lfd_state(lfd_state)
    );

    always #5 clock = ~clock;

    function automatic vec_t v(input logic rn, input logic pv, input logic pd, input logic [2:0] sr,
                               input logic ff, input logic lpv, input logic [2:0] emp,
                               input logic [1:0] din, input logic [7:0] exp);
        return '{rn, pv, pd, sr, ff, lpv, emp, din, exp};
    endfunction

    task automatic apply(input vec_t t);
        resetn = t.rn; pkt_valid = t.pv; parity_done = t.pd;
        {soft_reset_2, soft_reset_1, soft_reset_0} = t.sr;
        fifo_full = t.ff; low_pkt_valid = t.lpv;
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = t.emp;
        data_in = t.din;
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = {busy, detect_add, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, lfd_state};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: outputs got=%b want=%b", name, got, exp);
        end
    endtask

    initial begin
        //          rn  pv  pd  sr      ff  lpv emp     din    expected
        // plain packet
        tbl.push_back(v(0, 0, 0, 3'b000, 0, 0, 3'b000, 2'd0, S_DA));
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b001, 2'd0, S_LFD));
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b001, 2'd0, S_LD));
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b001, 2'd0, S_LD));
        tbl.push_back(v(1, 0, 0, 3'b000, 0, 0, 3'b001, 2'd0, S_LP));
        tbl.push_back(v(1, 0, 0, 3'b000, 0, 0, 3'b001, 2'd0, S_CPE));
        tbl.push_back(v(1, 0, 0, 3'b000, 0, 0, 3'b001, 2'd0, S_DA));
        // full stall, low_pkt_valid -> LP
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b100, 2'd2, S_LFD));
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b100, 2'd2, S_LD));
        tbl.push_back(v(1, 1, 0, 3'b000, 1, 0, 3'b100, 2'd2, S_FFS));
        tbl.push_back(v(1, 0, 0, 3'b000, 0, 1, 3'b100, 2'd2, S_LAF));
        tbl.push_back(v(1, 0, 0, 3'b000, 0, 1, 3'b100, 2'd2, S_LP));
        tbl.push_back(v(1, 0, 0, 3'b000, 0, 0, 3'b100, 2'd2, S_CPE));
        tbl.push_back(v(1, 0, 0, 3'b000, 0, 0, 3'b100, 2'd2, S_DA));
        // full stall, resume into LD
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b100, 2'd2, S_LFD));
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b100, 2'd2, S_LD));
        tbl.push_back(v(1, 1, 0, 3'b000, 1, 0, 3'b100, 2'd2, S_FFS));
        tbl.push_back(v(1, 1, 0, 3'b000, 1, 0, 3'b100, 2'd2, S_FFS));
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b100, 2'd2, S_LAF));
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b100, 2'd2, S_LD));
        tbl.push_back(v(1, 0, 0, 3'b000, 0, 0, 3'b100, 2'd2, S_LP));
        tbl.push_back(v(1, 0, 0, 3'b000, 0, 0, 3'b100, 2'd2, S_CPE));
        tbl.push_back(v(1, 0, 0, 3'b000, 0, 0, 3'b100, 2'd2, S_DA));
        // wait-till-empty on the latched address, not the live data_in
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b110, 2'd0, S_WTE));
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b110, 2'd1, S_WTE));
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b001, 2'd1, S_LFD));
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b001, 2'd0, S_LD));
        tbl.push_back(v(1, 0, 0, 3'b000, 0, 0, 3'b001, 2'd0, S_LP));
        tbl.push_back(v(1, 0, 0, 3'b000, 0, 0, 3'b001, 2'd0, S_CPE));
        tbl.push_back(v(1, 0, 0, 3'b000, 1, 0, 3'b001, 2'd0, S_FFS));
        tbl.push_back(v(1, 0, 1, 3'b000, 0, 0, 3'b001, 2'd0, S_LAF));
        tbl.push_back(v(1, 0, 1, 3'b000, 0, 0, 3'b001, 2'd0, S_DA));
        // soft reset in LD, hard reset in FFS
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b010, 2'd1, S_LFD));
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b010, 2'd1, S_LD));
        tbl.push_back(v(1, 1, 0, 3'b010, 0, 0, 3'b010, 2'd1, S_DA));
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b010, 2'd1, S_LFD));
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b010, 2'd1, S_LD));
        tbl.push_back(v(1, 1, 0, 3'b000, 1, 0, 3'b010, 2'd1, S_FFS));
        tbl.push_back(v(0, 1, 0, 3'b000, 1, 0, 3'b010, 2'd1, S_DA));
        // address 3 is ignored
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b111, 2'd3, S_DA));
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b111, 2'd3, S_DA));
        // full beats pkt_valid=0 in LD; soft reset in LAF
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b001, 2'd0, S_LFD));
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b001, 2'd0, S_LD));
        tbl.push_back(v(1, 0, 0, 3'b000, 1, 0, 3'b001, 2'd0, S_FFS));
        tbl.push_back(v(1, 0, 0, 3'b000, 0, 1, 3'b001, 2'd0, S_LAF));
        tbl.push_back(v(1, 0, 0, 3'b001, 0, 1, 3'b001, 2'd0, S_DA));
        // soft reset honoured in WTE
        tbl.push_back(v(1, 1, 0, 3'b000, 0, 0, 3'b000, 2'd2, S_WTE));
        tbl.push_back(v(1, 1, 0, 3'b100, 0, 0, 3'b000, 2'd2, S_DA));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // outputs must not follow inputs before the edge
        apply(v(1, 1, 0, 3'b000, 0, 0, 3'b001, 2'd0, S_DA));
        #2;
        check("no_comb_path", S_DA);
        @(posedge clock);
        #1;
        check("hdr_lfd", S_LFD);
        // reset in LFD overrides the unconditional LFD->LD
        resetn = 1'b0;
        @(posedge clock);
        #1;
        check("rst_in_lfd", S_DA);
        resetn = 1'b1;
        pkt_valid = 1'b0;
        @(posedge clock);
        #1;
        check("idle_da", S_DA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
